axi4_lite_regs: RTL and testbench

//  AXI4-Lite responder: terminates a single-ID AXI4-Lite port (e.g. the peripheral0 branch of the

---
 rtl/axi4_lite_regs.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_lite_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regs.sv
// axi4_lite_regs
//   AXI4-Lite responder holding NUM_REGS read/write 32-bit control registers
//   plus one read-only STATUS word at word offset NUM_REGS. AW, W and AR are
//   accepted independently; at most one write and one read are in flight.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   cfg_aw*              write address channel (only addr[ADDR_W-1:2] decoded)
//   cfg_w*               write data channel with byte strobes
//   cfg_b*               write response (OKAY / SLVERR)
//   cfg_ar*              read address channel (only addr[ADDR_W-1:2] decoded)
//   cfg_r*               read data / response
//   status_i             value returned for reads of word offset NUM_REGS
//   regs_o               register contents, reg n at [32n+31:32n]
//   wr_pulse_o           bit n pulses the cycle after reg n is written
module axi4_lite_regs #(
    parameter int          NUM_REGS  = 8,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_awvalid_i,
    input  logic [31:0]              cfg_awaddr_i,
    output logic                     cfg_awready_o,
    input  logic                     cfg_wvalid_i,
    input  logic [31:0]              cfg_wdata_i,
    input  logic [3:0]               cfg_wstrb_i,
    output logic                     cfg_wready_o,
    output logic                     cfg_bvalid_o,
    output logic [1:0]               cfg_bresp_o,
    input  logic                     cfg_bready_i,
    input  logic                     cfg_arvalid_i,
    input  logic [31:0]              cfg_araddr_i,
    output logic                     cfg_arready_o,
    output logic                     cfg_rvalid_o,
    output logic [31:0]              cfg_rdata_o,
    output logic [1:0]               cfg_rresp_o,
    input  logic                     cfg_rready_i,
    input  logic [31:0]              status_i,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int                IDX_W      = ADDR_W - 2;
    localparam logic [IDX_W-1:0]  STATUS_IDX = IDX_W'(NUM_REGS);
    localparam logic [1:0]        RESP_OKAY  = 2'b00;
    localparam logic [1:0]        RESP_SLV   = 2'b10;

    logic                 aw_held_q;
    logic [IDX_W-1:0]     aw_idx_q;
    logic                 w_held_q;
    logic [31:0]          w_data_q;
    logic [3:0]           w_strb_q;
    logic [31:0]          regs_q [NUM_REGS];
    logic                 bvalid_q;
    logic [1:0]           bresp_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;
    logic [NUM_REGS-1:0]  wr_pulse_q;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 commit;
    logic [IDX_W-1:0]     wr_idx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic                 wr_ok;
    logic [NUM_REGS-1:0]  wr_sel;
    logic [IDX_W-1:0]     rd_idx;
    logic [31:0]          rd_data;
    logic [1:0]           rd_resp;

    // Address bits outside the decoded window alias; consumed here only.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cfg_awaddr_i[31:ADDR_W], cfg_awaddr_i[1:0],
                                cfg_araddr_i[31:ADDR_W], cfg_araddr_i[1:0]};

    // Ready depends only on flops, never on the incoming valid.
    assign cfg_awready_o = !aw_held_q && !bvalid_q;
    assign cfg_wready_o  = !w_held_q && !bvalid_q;
    assign cfg_arready_o = !rvalid_q;

    assign aw_hs = cfg_awvalid_i && cfg_awready_o;
    assign w_hs  = cfg_wvalid_i && cfg_wready_o;
    assign ar_hs = cfg_arvalid_i && cfg_arready_o;

    // A write commits once both halves are either held or arriving now.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx  = aw_held_q ? aw_idx_q : cfg_awaddr_i[ADDR_W-1:2];
    assign wr_data = w_held_q ? w_data_q : cfg_wdata_i;
    assign wr_strb = w_held_q ? w_strb_q : cfg_wstrb_i;
    assign wr_ok   = wr_idx < STATUS_IDX;
    assign rd_idx  = cfg_araddr_i[ADDR_W-1:2];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wr_sel = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            wr_sel[n] = commit && (wr_idx == IDX_W'(n));
        end
    end

    // Read mux uses current register contents, so a same-cycle write commit
    // is not visible to the read.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLV;
        if (rd_idx == STATUS_IDX) begin
            rd_data = status_i;
            rd_resp = RESP_OKAY;
        end
        for (int n = 0; n < NUM_REGS; n++) begin
            if (rd_idx == IDX_W'(n)) begin
                rd_data = regs_q[n];
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= RESET_VAL;
            end
        end else begin
            if (commit) begin
                aw_held_q <= 1'b0;
            end else if (aw_hs) begin
                aw_held_q <= 1'b1;
            end
            if (aw_hs) aw_idx_q <= cfg_awaddr_i[ADDR_W-1:2];

            if (commit) begin
                w_held_q <= 1'b0;
            end else if (w_hs) begin
                w_held_q <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= cfg_wdata_i;
                w_strb_q <= cfg_wstrb_i;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLV;
            end else if (bvalid_q && cfg_bready_i) begin
                bvalid_q <= 1'b0;
            end

            // An all-zero strobe still gets an OKAY but is not an update.
            wr_pulse_q <= wr_sel & {NUM_REGS{wr_strb != 4'h0}};
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_sel[n]) regs_q[n] <= merge_bytes(regs_q[n], wr_data, wr_strb);
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && cfg_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign cfg_bvalid_o = bvalid_q;
    assign cfg_bresp_o  = bresp_q;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign cfg_rresp_o  = rresp_q;
    assign wr_pulse_o   = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4_lite_regs.sv
// Bench for axi4_lite_regs: directed AXI4-Lite transactions with a
// transaction-level model (register array plus AW/W queues) checked against
// the DUT on every falling edge, plus literal expectations per scenario.
module tb_axi4_lite_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, status;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] regs;
    logic [7:0]   pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_lite_regs dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_awvalid_i(awvalid), .cfg_awaddr_i(awaddr), .cfg_awready_o(awready),
        .cfg_wvalid_i(wvalid), .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb), .cfg_wready_o(wready),
        .cfg_bvalid_o(bvalid), .cfg_bresp_o(bresp), .cfg_bready_i(bready),
        .cfg_arvalid_i(arvalid), .cfg_araddr_i(araddr), .cfg_arready_o(arready),
        .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata), .cfg_rresp_o(rresp), .cfg_rready_i(rready),
        .status_i(status), .regs_o(regs), .wr_pulse_o(pulse)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0]  m_regs [8];
    logic [31:0]  q_aw [$];
    logic [31:0]  q_wd [$];
    logic [3:0]   q_ws [$];
    logic         m_bvalid, m_rvalid;
    logic [1:0]   m_bresp, m_rresp;
    logic [31:0]  m_rdata;
    logic [7:0]   m_pulse;
    bit           m_live = 0;
    bit           aw_take, w_take, ar_take;
    int           m_idx;
    logic [31:0]  m_a, m_d;
    logic [3:0]   m_s;
    logic [255:0] exp_regs;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
            q_aw.delete(); q_wd.delete(); q_ws.delete();
            m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0;
            m_rdata = 0; m_pulse = 0; m_live = 1;
        end else begin
            aw_take = awvalid && q_aw.size() == 0 && !m_bvalid;
            w_take  = wvalid && q_wd.size() == 0 && !m_bvalid;
            ar_take = arvalid && !m_rvalid;
            m_pulse = 0;
            if (m_rvalid && rready) m_rvalid = 0;
            if (ar_take) begin
                m_idx = int'(araddr[7:2]);
                m_rvalid = 1;
                if (m_idx < 8) begin
                    m_rdata = m_regs[m_idx]; m_rresp = 2'b00;
                end else if (m_idx == 8) begin
                    m_rdata = status; m_rresp = 2'b00;
                end else begin
                    m_rdata = 0; m_rresp = 2'b10;
                end
            end
            if (m_bvalid && bready) m_bvalid = 0;
            if (aw_take) q_aw.push_back(awaddr);
            if (w_take) begin
                q_wd.push_back(wdata);
                q_ws.push_back(wstrb);
            end
            if (q_aw.size() > 0 && q_wd.size() > 0) begin
                m_a = q_aw.pop_front(); m_d = q_wd.pop_front(); m_s = q_ws.pop_front();
                m_idx = int'(m_a[7:2]);
                m_bvalid = 1;
                if (m_idx < 8) begin
                    for (int b = 0; b < 4; b++)
                        if (m_s[b]) m_regs[m_idx][8*b +: 8] = m_d[8*b +: 8];
                    m_bresp = 2'b00;
                    if (m_s != 0) m_pulse = 8'(1 << m_idx);
                end else begin
                    m_bresp = 2'b10;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live && rst_n) begin
            for (int n = 0; n < 8; n++) exp_regs[32*n +: 32] = m_regs[n];
            chk("m_regs", regs, exp_regs);
            chk("m_pulse", 256'(pulse), 256'(m_pulse));
            chk("m_bvalid", 256'(bvalid), 256'(m_bvalid));
            chk("m_rvalid", 256'(rvalid), 256'(m_rvalid));
            chk("m_awready", 256'(awready), 256'(q_aw.size() == 0 && !m_bvalid));
            chk("m_wready", 256'(wready), 256'(q_wd.size() == 0 && !m_bvalid));
            chk("m_arready", 256'(arready), 256'(!m_rvalid));
            if (m_bvalid) chk("m_bresp", 256'(bresp), 256'(m_bresp));
            if (m_rvalid) begin
                chk("m_rdata", 256'(rdata), 256'(m_rdata));
                chk("m_rresp", 256'(rresp), 256'(m_rresp));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [7:0] pulse_seen, output logic bv_seen);
        bit aw_d = 0;
        bit w_d = 0;
        awvalid = 1; awaddr = addr; wvalid = 1; wdata = data; wstrb = strb;
        for (int i = 0; i < 20 && !(aw_d && w_d); i++) begin
            @(negedge clk);
            if (awvalid && awready) aw_d = 1;
            if (wvalid && wready) w_d = 1;
            @(posedge clk); #1;
            if (aw_d) awvalid = 0;
            if (w_d) wvalid = 0;
        end
        awvalid = 0; wvalid = 0;
        chk("write_accept", 256'(aw_d && w_d), 256'(1));
        @(negedge clk);
        pulse_seen = pulse;
        bv_seen = bvalid;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        bit ok = 0;
        awvalid = 1; awaddr = addr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
            @(posedge clk); #1;
        end
        awvalid = 0;
        chk("aw_accept", 256'(ok), 256'(1));
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit ok = 0;
        wvalid = 1; wdata = data; wstrb = strb;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = wready;
            @(posedge clk); #1;
        end
        wvalid = 0;
        chk("w_accept", 256'(ok), 256'(1));
    endtask

    task automatic wait_b(input int hold, input logic [1:0] exp_resp);
        int n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_arrive", 256'(bvalid), 256'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("aw_blocked", 256'(awready), 256'(0));
            chk("b_held", 256'(bvalid), 256'(1));
        end
        chk("b_resp", 256'(bresp), 256'(exp_resp));
        step();
        bready = 1;
        step();
        bready = 0;
        @(negedge clk);
        chk("b_single", 256'(bvalid), 256'(0));
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        bit ok = 0;
        step();
        arvalid = 1; araddr = addr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        chk("ar_accept", 256'(ok), 256'(1));
        @(negedge clk);
        chk("r_latency", 256'(rvalid), 256'(1));
        d = rdata;
        r = rresp;
        step();
        rready = 1;
        step();
        rready = 0;
    endtask

    // ---------------- scenarios ----------------
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [7:0]  ps;
    logic        bv;

    initial begin
        rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; status = 32'hCAFE0001;
        step(); step(); step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_regs", regs, 256'(0));
        chk("rst_bvalid", 256'(bvalid), 256'(0));
        chk("rst_rvalid", 256'(rvalid), 256'(0));

        // reset values
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), rd, rr);
            chk("rst_read", 256'(rd), 256'(0));
            chk("rst_rresp", 256'(rr), 256'(0));
        end

        // AW and W together
        step();
        do_write(32'h04, 32'hDEADBEEF, 4'hF, ps, bv);
        chk("t2_pulse", 256'(ps), 256'(8'h02));
        chk("t2_bvalid_lat", 256'(bv), 256'(1));
        wait_b(0, 2'b00);
        do_read(32'h04, rd, rr);
        chk("t2_read", 256'(rd), 256'(32'hDEADBEEF));

        // W three cycles ahead of AW, slow bready
        step();
        send_w(32'h000000AA, 4'b0001);
        step(); step();
        send_aw(32'h04);
        @(negedge clk);
        chk("t3_bvalid_lat", 256'(bvalid), 256'(1));
        chk("t3_pulse", 256'(pulse), 256'(8'h02));
        wait_b(5, 2'b00);
        chk("t3_reg1", 256'(regs[63:32]), 256'(32'hDEADBEAA));
        do_read(32'h04, rd, rr);
        chk("t3_read", 256'(rd), 256'(32'hDEADBEAA));

        // STATUS is read-only, beyond it is an error
        step();
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, ps, bv);
        chk("t4_pulse", 256'(ps), 256'(0));
        wait_b(0, 2'b10);
        chk("t4_reg1", 256'(regs[63:32]), 256'(32'hDEADBEAA));
        status = 32'h12345678;
        do_read(32'h20, rd, rr);
        chk("t4_status", 256'(rd), 256'(32'h12345678));
        chk("t4_status_resp", 256'(rr), 256'(2'b00));
        do_read(32'h24, rd, rr);
        chk("t4_oob_data", 256'(rd), 256'(0));
        chk("t4_oob_resp", 256'(rr), 256'(2'b10));

        // aliased address: 0xFFFFFF0F decodes to reg 3
        step();
        do_write(32'hFFFFFF0F, 32'hABCD1234, 4'b0011, ps, bv);
        chk("alias_pulse", 256'(ps), 256'(8'h08));
        wait_b(0, 2'b00);
        do_read(32'h0C, rd, rr);
        chk("alias_read", 256'(rd), 256'(32'h00001234));

        // read and write commit to the same register on one edge
        step();
        do_write(32'h08, 32'h11111111, 4'hF, ps, bv);
        wait_b(0, 2'b00);
        step();
        awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h08;
        @(negedge clk);
        chk("t5_ready", 256'({awready, wready, arready}), 256'(3'b111));
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        chk("t5_old", 256'(rdata), 256'(32'h11111111));
        chk("t5_bvalid", 256'(bvalid), 256'(1));
        step();
        rready = 1; bready = 1;
        step();
        rready = 0; bready = 0;
        do_read(32'h08, rd, rr);
        chk("t5_new", 256'(rd), 256'(32'h00000055));

        // reset with a response pending and a W waiting
        step();
        do_write(32'h00, 32'hA5A5A5A5, 4'hF, ps, bv);
        wvalid = 1; wdata = 32'h99999999; wstrb = 4'hF;
        step();
        rst_n = 0;
        step(); step();
        rst_n = 1; wvalid = 0;
        @(negedge clk);
        chk("t6_bvalid", 256'(bvalid), 256'(0));
        chk("t6_regs", regs, 256'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_stray_b", 256'(bvalid), 256'(0));
        end

        // W held when reset hits must not pair with a later AW
        step();
        send_w(32'h77777777, 4'hF);
        rst_n = 0;
        step(); step();
        rst_n = 1;
        send_aw(32'h0C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_w_dropped", 256'(bvalid), 256'(0));
        end
        chk("t6_reg3", 256'(regs[127:96]), 256'(0));
        step();
        send_w(32'h00000012, 4'h1);
        wait_b(0, 2'b00);
        do_read(32'h0C, rd, rr);
        chk("t6_read", 256'(rd), 256'(32'h00000012));

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
